counter_seg_display: RTL

Downstream display stage for the 4-bit counter. Consumes the counter's `q` value and `cout` carry and accumulates carries into a 4-bit high digit. It latches both digits, with an optional freeze, and drives a two-digit, time-multiplexed 7-segment display in hexadecimal. The counter plus this block form a 2-digit hex event counter on the board.

---
 rtl/counter_seg_display.sv | 115 +++++++++++
 1 files changed

// File: rtl/counter_seg_display.sv
// Display stage for a 4-bit counter: accumulates carries into a high hex digit,
// latches both digits (with freeze) and scans them onto a two-digit 7-segment display.
module counter_seg_display #(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q,
  input  logic       cout,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] hi,
  output logic       ovf
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  // Hex font in {g,f,e,d,c,b,a} order, with the board's drive polarity applied.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'h0: c = 7'h3F;
      4'h1: c = 7'h06;
      4'h2: c = 7'h5B;
      4'h3: c = 7'h4F;
      4'h4: c = 7'h66;
      4'h5: c = 7'h6D;
      4'h6: c = 7'h7D;
      4'h7: c = 7'h07;
      4'h8: c = 7'h7F;
      4'h9: c = 7'h6F;
      4'hA: c = 7'h77;
      4'hB: c = 7'h7C;
      4'hC: c = 7'h39;
      4'hD: c = 7'h5E;
      4'hE: c = 7'h79;
      default: c = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~c : c;
  endfunction

  logic             r_cout_d;
  logic [3:0]       r_hi;
  logic             r_ovf;
  logic [3:0]       r_disp_lo;
  logic [3:0]       r_disp_hi;
  logic [PRE_W-1:0] r_pre;
  logic             r_sel;
  logic [1:0]       r_an;
  logic [6:0]       r_seg;

  logic       w_carry;
  logic [3:0] w_digit;

  assign w_carry = cout & ~r_cout_d;
  assign w_digit = r_sel ? r_disp_hi : r_disp_lo;

  // NOTE: every register uses <= so all blocks see pre-edge values; disp_hi
  // therefore captures hi before this edge's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cout_d <= 1'b0;
      r_hi     <= 4'h0;
      r_ovf    <= 1'b0;
    end else begin
      r_cout_d <= cout;
      if (w_carry) begin
        r_hi <= r_hi + 4'h1;
        if (r_hi == 4'hF) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_lo <= 4'h0;
      r_disp_hi <= 4'h0;
    end else if (!freeze) begin
      r_disp_lo <= q;
      r_disp_hi <= r_hi;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_sel <= 1'b0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Registered drive keeps anode and segment changes aligned on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= 2'b10;
      r_seg <= seg_code(4'h0);
    end else begin
      r_an  <= r_sel ? 2'b01 : 2'b10;
      r_seg <= seg_code(w_digit);
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign hi  = r_hi;
  assign ovf = r_ovf;

endmodule
